// File: rtl/vga_pkg.sv
// vga_pkg: shared widths, default screen size and arbiter state encoding
// for the vga_adapter pixel-port arbiters.
//   X_W / Y_W / COLOR_W : pixel coordinate and colour widths
//   H_RES_DEF / V_RES_DEF : default visible resolution
//   arb_state_t : OPEN (round-robin) or LOCKED (one owner holds the port)
package vga_pkg;

   localparam int X_W       = 8;
   localparam int Y_W       = 7;
   localparam int COLOR_W   = 3;
   localparam int H_RES_DEF = 160;
   localparam int V_RES_DEF = 120;

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   // True when a pixel lies inside the visible area.
   function automatic logic pixel_visible(input logic [X_W-1:0] x,
                                          input logic [Y_W-1:0] y,
                                          input int h_res,
                                          input int v_res);
      return ({{(32-X_W){1'b0}}, x} < 32'(h_res)) &&
             ({{(32-Y_W){1'b0}}, y} < 32'(v_res));
   endfunction

endpackage

// File: rtl/vga_plot_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority search.
//   req   : request vector
//   ptr   : index of the last grant; search starts at ptr+1 and wraps
//   grant : one-hot grant (all zero when no request)
//   idx   : binary index of the granted requester
//   any   : high when some request was granted
module rr_picker #(
   parameter int N     = 2,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   // Outer loop walks priority order (ptr+1, ptr+2, ...); the first hit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (((int'(ptr) + k) % N) == i)) begin
               grant[i] = 1'b1;
               idx      = PTR_W'(i);
               any      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the vga_adapter pixel-write port between
// NUM_REQ producers, one pixel per clock, round-robin with optional lock.
//   clk, reset          : clock, asynchronous active-high reset
//   req, lock           : per-requester pixel valid / keep-ownership flag
//   x_in, y_in, color_in: packed per-requester pixel data
//   ack                 : combinational grant, transfer on req & ack
//   xpos, ypos, color, plot : registered pixel write to vga_adapter
//   owner, locked       : current lock owner and lock status
//   drop_cnt            : saturating count of off-screen pixels dropped
module vga_plot_arbiter
   import vga_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int H_RES        = H_RES_DEF,
   parameter int V_RES        = V_RES_DEF,
   parameter int LOCK_TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         lock,
   input  logic [X_W*NUM_REQ-1:0]     x_in,
   input  logic [Y_W*NUM_REQ-1:0]     y_in,
   input  logic [COLOR_W*NUM_REQ-1:0] color_in,
   output logic [NUM_REQ-1:0]         ack,
   output logic [X_W-1:0]             xpos,
   output logic [Y_W-1:0]             ypos,
   output logic [COLOR_W-1:0]         color,
   output logic                       plot,
   output logic [1:0]                 owner,
   output logic                       locked,
   output logic [7:0]                 drop_cnt
);

   localparam int PTR_W = 2;
   localparam int CNT_W = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

   arb_state_t          state_q;
   logic [PTR_W-1:0]    ptr_q;
   logic [PTR_W-1:0]    owner_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [X_W-1:0]      xpos_q, xpos_d;
   logic [Y_W-1:0]      ypos_q, ypos_d;
   logic [COLOR_W-1:0]  color_q, color_d;
   logic                plot_q, plot_d;
   logic [7:0]          drop_q, drop_d;

   logic [X_W-1:0]      x_arr [NUM_REQ];
   logic [Y_W-1:0]      y_arr [NUM_REQ];
   logic [COLOR_W-1:0]  c_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign x_arr[gi] = x_in[gi*X_W +: X_W];
         assign y_arr[gi] = y_in[gi*Y_W +: Y_W];
         assign c_arr[gi] = color_in[gi*COLOR_W +: COLOR_W];
      end
   endgenerate

   logic [NUM_REQ-1:0] pick_grant;
   logic [PTR_W-1:0]   pick_idx;
   logic               pick_any;

   rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   logic [NUM_REQ-1:0] owner_ack;
   logic [PTR_W-1:0]   win_idx;
   logic               xfer;
   logic               win_lock;
   logic [X_W-1:0]     win_x;
   logic [Y_W-1:0]     win_y;
   logic [COLOR_W-1:0] win_c;
   logic               win_visible;

   // Grant selection and winner data mux; index compares avoid
   // out-of-range selects when NUM_REQ is not a power of two.
   always_comb begin
      owner_ack = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         owner_ack[i] = req[i] && (owner_q == PTR_W'(i));
      end
      if (state_q == ST_OPEN) begin
         ack     = pick_grant;
         win_idx = pick_idx;
         xfer    = pick_any;
      end else begin
         ack     = owner_ack;
         win_idx = owner_q;
         xfer    = |owner_ack;
      end
      win_lock = 1'b0;
      win_x    = '0;
      win_y    = '0;
      win_c    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == PTR_W'(i)) begin
            win_lock = lock[i];
            win_x    = x_arr[i];
            win_y    = y_arr[i];
            win_c    = c_arr[i];
         end
      end
      win_visible = pixel_visible(win_x, win_y, H_RES, V_RES);
   end

   // Pixel output path: data is captured on every transfer, even when the
   // pixel is off-screen; only the strobe is suppressed.
   always_comb begin
      xpos_d  = xpos_q;
      ypos_d  = ypos_q;
      color_d = color_q;
      plot_d  = 1'b0;
      drop_d  = drop_q;
      if (xfer) begin
         xpos_d  = win_x;
         ypos_d  = win_y;
         color_d = win_c;
         plot_d  = win_visible;
         if (!win_visible && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xpos_q  <= '0;
         ypos_q  <= '0;
         color_q <= '0;
         plot_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         xpos_q  <= xpos_d;
         ypos_q  <= ypos_d;
         color_q <= color_d;
         plot_q  <= plot_d;
         drop_q  <= drop_d;
      end
   end

   // Ownership FSM. The pointer only moves on OPEN transfers, so after a
   // lock ends (by transfer or timeout) the search resumes at owner+1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_OPEN;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_OPEN: begin
               if (xfer) begin
                  ptr_q <= win_idx;
                  if (win_lock) begin
                     state_q <= ST_LOCKED;
                     owner_q <= win_idx;
                     cnt_q   <= '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (xfer) begin
                  cnt_q <= '0;
                  if (!win_lock) begin
                     state_q <= ST_OPEN;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= ST_OPEN;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_OPEN;
         endcase
      end
   end

   assign xpos     = xpos_q;
   assign ypos     = ypos_q;
   assign color    = color_q;
   assign plot     = plot_q;
   assign drop_cnt = drop_q;
   assign owner    = owner_q;
   assign locked   = (state_q == ST_LOCKED);

endmodule
